// File: rtl/video_to_axis_framer.sv
// video_to_axis_framer
//   Frames a raw DE/VSYNC pixel stream into AXI4-Stream beats. The first pixel
//   of a frame carries tuser and the last pixel of each line carries tlast.
//   A small first-word-fall-through FIFO sits on the output. Pixels that arrive
//   while the FIFO is full are dropped, and the framer then discards the rest
//   of the frame. Short lines and short frames are reported on line_err.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   vid_data/de/vsync raw video input (no backpressure)
//   m_axis_*          AXI4-Stream master (tdata/tvalid/tlast/tuser, tready in)
//   overflow          one-cycle pulse when a pixel is dropped on a full FIFO
//   line_err          one-cycle pulse on a short line or short frame
//   frame_count       completed frames (only when FRAME_STATS_EN is defined)
//   drop_count        entries into DROP (only when FRAME_STATS_EN is defined)
//
// Build option: define FRAME_STATS_EN to add the frame_count/drop_count ports.
//
// state  | meaning
// IDLE   | between frames, de pixels ignored
// ARMED  | vsync seen, waiting for the first pixel of the frame
// ACTIVE | inside a frame, pixels written to the FIFO
// DROP   | frame abandoned, discard until next vsync rising edge
module video_to_axis_framer #(
  parameter int WIDTH      = 1920,
  parameter int HEIGHT     = 1080,
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  vid_de,
  input  logic                  vid_vsync,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic                  line_err
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DROP} state_t;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  de_q, de_prev_q, vsync_q, vsync_prev_q;
  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  ovf_q, ovf_d, lerr_q, lerr_d;
  logic                  push, push_last, push_user, pop;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  vis_q;
  logic                  fifo_full, vs_rise, de_fall;
  logic [EW-1:0]         head;

  // Both vsync registers reset high so a vsync already asserted at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      de_q         <= 1'b0;
      de_prev_q    <= 1'b0;
      vsync_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
    end else begin
      data_q       <= vid_data;
      de_q         <= vid_de;
      de_prev_q    <= de_q;
      vsync_q      <= vid_vsync;
      vsync_prev_q <= vsync_q;
    end
  end

  assign vs_rise   = vsync_q & ~vsync_prev_q;
  assign de_fall   = de_prev_q & ~de_q;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_user = 1'b0;
    ovf_d     = 1'b0;
    lerr_d    = 1'b0;
    if (vs_rise) begin
      // A vsync inside ACTIVE means the previous frame came up short.
      if (state_q == ACTIVE) lerr_d = 1'b1;
      state_d = ARMED;
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        ARMED, ACTIVE: begin
          if (de_q) begin
            if (!fifo_full) begin
              push      = 1'b1;
              push_user = (state_q == ARMED);
              push_last = (x_q == X_LAST);
              state_d   = ACTIVE;
              if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                  y_d     = '0;
                  state_d = IDLE;
                end else begin
                  y_d = y_q + 1'b1;
                end
              end else begin
                x_d = x_q + 1'b1;
              end
            end else begin
              ovf_d   = 1'b1;
              state_d = DROP;
            end
          end else if (state_q == ACTIVE && de_fall && x_q != '0) begin
            lerr_d  = 1'b1;
            state_d = DROP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_user, data_q};
  end

  // vis_q delays visibility of the first entry into an empty FIFO by one
  // cycle, giving a two-edge sample-to-tvalid latency. Entries written while
  // the FIFO already holds data are visible as soon as they reach the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vis_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      vis_q   <= (count_q != '0);
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tvalid = vis_q & (count_q != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tuser  = m_axis_tvalid & head[DATA_WIDTH];
  assign m_axis_tlast  = m_axis_tvalid & head[DATA_WIDTH+1];
  assign overflow      = ovf_q;
  assign line_err      = lerr_q;

`ifdef FRAME_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (state_d == IDLE && state_q != IDLE) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (state_d == DROP && state_q != DROP) drop_cnt_q  <= drop_cnt_q + 1'b1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

endmodule
